// File: rtl/aes_state_ser_if.sv
// Block-in / byte-out bus of the AES state serializer.
// Optional dout_last signal is present only when AES_SER_LAST_EN is defined.
interface aes_state_ser_if;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned BYTE_W = 8;

    logic [BLK_W-1:0]  blk;
    logic              blk_valid;
    logic              blk_ready;
    logic              mode;
    logic [BYTE_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              busy;
    logic              done;
`ifdef AES_SER_LAST_EN
    logic              dout_last;
`endif

    // Block source and byte sink side
    modport master (
        output blk, blk_valid, mode, dout_ready,
        input  blk_ready, dout, dout_valid, busy, done
`ifdef AES_SER_LAST_EN
        , dout_last
`endif
    );

    // Serializer side
    modport slave (
        input  blk, blk_valid, mode, dout_ready,
        output blk_ready, dout, dout_valid, busy, done
`ifdef AES_SER_LAST_EN
        , dout_last
`endif
    );
endinterface

// File: rtl/aes_state_ser.sv
// AES state serializer: captures a 128-bit block and streams 16 bytes over
// a valid/ready handshake, MSB-first (mode=0) or LSB-first (mode=1).
// Optional feature macro: AES_SER_LAST_EN adds dout_last marking the 16th byte.
module aes_state_ser (
    input  logic            clk,
    input  logic            rst,
    aes_state_ser_if.slave  bus
);
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(15);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [BLK_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ord_q, ord_d;
    logic               done_q, done_d;
    logic               xfer;

    assign xfer = (state_q == SEND) && bus.dout_ready;

    // State and datapath registers; reset drops any in-flight block
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            ord_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ord_q   <= ord_d;
            done_q  <= done_d;
        end
    end

    // Next-state: capture in IDLE, shift toward the emitting end on each handshake
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ord_d   = ord_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.blk_valid) begin
                    sr_d    = bus.blk;
                    ord_d   = bus.mode;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (ord_q) begin
                        sr_d = {BYTE_W'(0), sr_q[BLK_W-1:BYTE_W]};
                    end else begin
                        sr_d = {sr_q[BLK_W-BYTE_W-1:0], BYTE_W'(0)};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode straight from registered state
    assign bus.blk_ready  = (state_q == IDLE);
    assign bus.dout_valid = (state_q == SEND);
    assign bus.busy       = (state_q == SEND);
    assign bus.dout       = ord_q ? sr_q[BYTE_W-1:0] : sr_q[BLK_W-1:BLK_W-BYTE_W];
    assign bus.done       = done_q;
`ifdef AES_SER_LAST_EN
    assign bus.dout_last  = (state_q == SEND) && (cnt_q == LAST_CNT);
`endif

endmodule

// File: tb/tb_aes_state_ser.sv
// Self-checking bench for aes_state_ser against a byte-list reference model.
module tb_aes_state_ser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    aes_state_ser_if ser_if ();

    aes_state_ser u_dut (
        .clk (clk),
        .rst (rst),
        .bus (ser_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    localparam logic [127:0] FIPS_BLK = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] SEQ_BLK  = 128'h000102030405060708090a0b0c0d0e0f;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: byte k of the stream is block byte (15-k) for mode 0, k for mode 1
    function automatic logic [7:0] ref_byte(input logic [127:0] b, input logic m, input int k);
        int idx;
        idx = m ? k : 15 - k;
        return b[idx*8 +: 8];
    endfunction

    function automatic logic ref_last(input int k);
        return (k == 15);
    endfunction

    // Streams one block with optional stall, mid-stream blk_valid pulse and mode scrambling
    task automatic stream_block(input logic [127:0] b, input logic m, input int stall_idx,
                                input int stall_len, input int pulse_idx, input bit scramble,
                                input string tag);
        int edges;
        logic [7:0] exp_b;
        ser_if.blk       = b;
        ser_if.mode      = m;
        ser_if.blk_valid = 1'b1;
        step();
        ser_if.blk_valid = 1'b0;
        ser_if.blk       = {$urandom, $urandom, $urandom, $urandom};
        edges = 1;
        for (int i = 0; i < 16; i++) begin
            exp_b = ref_byte(b, m, i);
            if (scramble) ser_if.mode = 1'($urandom);
            checks++;
            if ({ser_if.dout_valid, ser_if.dout, ser_if.busy, ser_if.blk_ready, ser_if.done}
                !== {1'b1, exp_b, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL %s byte %0d: valid/dout/busy/ready/done got %b/%h/%b/%b/%b want 1/%h/1/0/0",
                         tag, i, ser_if.dout_valid, ser_if.dout, ser_if.busy, ser_if.blk_ready,
                         ser_if.done, exp_b);
            end
`ifdef AES_SER_LAST_EN
            checks++;
            if (ser_if.dout_last !== ref_last(i)) begin
                errors++;
                $display("FAIL %s last byte %0d: got %b want %b", tag, i, ser_if.dout_last, ref_last(i));
            end
`endif
            if (i == pulse_idx) begin
                ser_if.blk       = '1;
                ser_if.blk_valid = 1'b1;
            end
            if (i == stall_idx) begin
                ser_if.dout_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    step();
                    edges++;
                    ser_if.blk_valid = 1'b0;
                    checks++;
                    if ({ser_if.dout_valid, ser_if.dout, ser_if.blk_ready, ser_if.done}
                        !== {1'b1, exp_b, 1'b0, 1'b0}) begin
                        errors++;
                        $display("FAIL %s stall %0d at byte %0d: valid/dout/ready/done got %b/%h/%b/%b want 1/%h/0/0",
                                 tag, s, i, ser_if.dout_valid, ser_if.dout, ser_if.blk_ready,
                                 ser_if.done, exp_b);
                    end
`ifdef AES_SER_LAST_EN
                    checks++;
                    if (ser_if.dout_last !== ref_last(i)) begin
                        errors++;
                        $display("FAIL %s stall last byte %0d: got %b want %b", tag, i,
                                 ser_if.dout_last, ref_last(i));
                    end
`endif
                end
                ser_if.dout_ready = 1'b1;
            end
            step();
            edges++;
            ser_if.blk_valid = 1'b0;
        end
        // Done cycle: edges counts from the accept edge, so done lands in cycle N+17+stall
        checks++;
        if ({ser_if.done, ser_if.blk_ready, ser_if.dout_valid, ser_if.busy, ser_if.dout}
            !== {1'b1, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL %s done cycle %0d: done/ready/valid/busy/dout got %b/%b/%b/%b/%h want 1/1/0/0/00",
                     tag, edges, ser_if.done, ser_if.blk_ready, ser_if.dout_valid, ser_if.busy,
                     ser_if.dout);
        end
`ifdef AES_SER_LAST_EN
        checks++;
        if (ser_if.dout_last !== 1'b0) begin
            errors++;
            $display("FAIL %s last in done cycle: got %b want 0", tag, ser_if.dout_last);
        end
`endif
        checks++;
        if (edges !== 17 + ((stall_idx >= 0) ? stall_len : 0)) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, edges,
                     17 + ((stall_idx >= 0) ? stall_len : 0));
        end
    endtask

    task automatic check_idle_after(input string tag);
        step();
        checks++;
        if ({ser_if.done, ser_if.blk_ready, ser_if.dout_valid, ser_if.dout}
            !== {1'b0, 1'b1, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL %s idle: done/ready/valid/dout got %b/%b/%b/%h want 0/1/0/00",
                     tag, ser_if.done, ser_if.blk_ready, ser_if.dout_valid, ser_if.dout);
        end
    endtask

    task automatic test_reset();
        ser_if.blk        = '0;
        ser_if.blk_valid  = 1'b0;
        ser_if.mode       = 1'b0;
        ser_if.dout_ready = 1'b1;
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({ser_if.blk_ready, ser_if.dout_valid, ser_if.busy, ser_if.done, ser_if.dout}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset: ready/valid/busy/done/dout got %b/%b/%b/%b/%h want 1/0/0/0/00",
                     ser_if.blk_ready, ser_if.dout_valid, ser_if.busy, ser_if.done, ser_if.dout);
        end
`ifdef AES_SER_LAST_EN
        checks++;
        if (ser_if.dout_last !== 1'b0) begin
            errors++;
            $display("FAIL reset last: got %b want 0", ser_if.dout_last);
        end
`endif
        rst = 1'b0;
        // dout_ready with nothing valid must not start anything
        step();
        step();
        checks++;
        if ({ser_if.blk_ready, ser_if.dout_valid, ser_if.done} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL idle ready: ready/valid/done got %b/%b/%b want 1/0/0",
                     ser_if.blk_ready, ser_if.dout_valid, ser_if.done);
        end
    endtask

    task automatic test_msb_first();
        stream_block(FIPS_BLK, 1'b0, -1, 0, -1, 1'b0, "msb");
        check_idle_after("msb");
    endtask

    task automatic test_lsb_first();
        stream_block(FIPS_BLK, 1'b1, -1, 0, -1, 1'b1, "lsb");
        check_idle_after("lsb");
    endtask

    task automatic test_stall();
        stream_block(FIPS_BLK, 1'b0, 5, 3, -1, 1'b0, "stall5");
        check_idle_after("stall5");
        stream_block(FIPS_BLK, 1'b1, 15, 4, -1, 1'b0, "stall15");
        check_idle_after("stall15");
    endtask

    task automatic test_ignore_mid_block();
        stream_block(FIPS_BLK, 1'b0, -1, 0, 6, 1'b0, "ignore");
        check_idle_after("ignore");
    endtask

    task automatic test_reset_mid_block();
        ser_if.blk       = FIPS_BLK;
        ser_if.mode      = 1'b0;
        ser_if.blk_valid = 1'b1;
        step();
        ser_if.blk_valid = 1'b0;
        for (int i = 0; i < 8; i++) step();
        rst = 1'b1;
        #1;
        checks++;
        if ({ser_if.dout_valid, ser_if.busy, ser_if.dout, ser_if.blk_ready, ser_if.done}
            !== {1'b0, 1'b0, 8'h00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async reset: valid/busy/dout/ready/done got %b/%b/%h/%b/%b want 0/0/00/1/0",
                     ser_if.dout_valid, ser_if.busy, ser_if.dout, ser_if.blk_ready, ser_if.done);
        end
        step();
        rst = 1'b0;
        step();
        stream_block(SEQ_BLK, 1'b0, -1, 0, -1, 1'b0, "post_rst");
        check_idle_after("post_rst");
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 6; n++) begin
            logic [127:0] b;
            b = {$urandom, $urandom, $urandom, $urandom};
            stream_block(b, 1'($urandom), ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1,
                         int'($urandom_range(1, 4)), -1, 1'b1, "b2b");
        end
        check_idle_after("b2b");
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall();
        test_ignore_mid_block();
        test_reset_mid_block();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
